// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: general-purpose register file with two combinational
// read ports, one clocked writeback port, optional hardwired-zero R0,
// optional write-to-read bypass, and a per-register pending-write scoreboard
// used by decode for hazard stalls.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              flush,
    output logic              rsv_conflict,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    // Register storage and scoreboard state
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_p1;
    logic [NUM_REGS-1:0] busy_next;
    logic                conflict_p1;
    logic                conflict_next;
    logic [ADDR_W:0]     cnt_p1;

    // Qualified requests: R0 (when hardwired) swallows writes and reservations,
    // and a flush squashes the reservation of the instruction leaving decode.
    logic wr_ok;
    logic rsv_ok;

    // True when the address names the hardwired-zero register.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Number of set bits in the busy vector.
    function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Forwarding hit: the writeback of this cycle targets the read address.
    function automatic logic bypass_hit(input logic                wr_valid,
                                        input logic [ADDR_W-1:0] waddr,
                                        input logic [ADDR_W-1:0] raddr);
        return (BYPASS != 0) && wr_valid && (waddr == raddr);
    endfunction

    assign wr_ok  = wr_en && !is_zero_reg(wr_addr);
    assign rsv_ok = rsv_en && !flush && !is_zero_reg(rsv_addr);

    // Writeback into the storage array; reset clears every register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Scoreboard next state: flush beats reserve, reserve beats release.
    always_comb begin
        busy_next     = busy_p1;
        conflict_next = 1'b0;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (wr_ok) begin
                busy_next[wr_addr] = 1'b0;
            end
            if (rsv_ok) begin
                busy_next[rsv_addr] = 1'b1;
                // A reservation on a register that a same-cycle write is
                // releasing is a clean hand-over, not a WAW conflict.
                conflict_next = busy_p1[rsv_addr] && !(wr_ok && (wr_addr == rsv_addr));
            end
        end
    end

    // Scoreboard state, conflict pulse and pending count all move on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_p1     <= '0;
            conflict_p1 <= 1'b0;
            cnt_p1      <= '0;
        end else begin
            busy_p1     <= busy_next;
            conflict_p1 <= conflict_next;
            cnt_p1      <= popcount(busy_next);
        end
    end

    assign rsv_conflict = conflict_p1;
    assign pending_cnt  = cnt_p1;

    // Read port A: stored value, overridden by same-cycle writeback when bypassing.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (bypass_hit(wr_ok, wr_addr, rd_addr_a)) begin
            rd_data_a = wr_data;
        end
        if (reset || is_zero_reg(rd_addr_a)) begin
            rd_data_a = '0;
        end
    end

    // Read port B: same selection as port A.
    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if (bypass_hit(wr_ok, wr_addr, rd_addr_b)) begin
            rd_data_b = wr_data;
        end
        if (reset || is_zero_reg(rd_addr_b)) begin
            rd_data_b = '0;
        end
    end

    // Busy flags: a forwarded writeback satisfies the hazard unless the same
    // register is being re-reserved by a new producer this cycle.
    always_comb begin
        rd_busy_a = busy_p1[rd_addr_a];
        rd_busy_b = busy_p1[rd_addr_b];
        if (bypass_hit(wr_ok, wr_addr, rd_addr_a) && !(rsv_ok && (rsv_addr == rd_addr_a))) begin
            rd_busy_a = 1'b0;
        end
        if (bypass_hit(wr_ok, wr_addr, rd_addr_b) && !(rsv_ok && (rsv_addr == rd_addr_b))) begin
            rd_busy_b = 1'b0;
        end
        if (reset || is_zero_reg(rd_addr_a)) begin
            rd_busy_a = 1'b0;
        end
        if (reset || is_zero_reg(rd_addr_b)) begin
            rd_busy_b = 1'b0;
        end
    end

endmodule
